// File: rtl/sme_arbiter.sv
// Two-requester round-robin front end for one shared string-matching engine.
// Define SME_ARB_TIMEOUT_EN to abort a job after TIMEOUT_CYCLES cycles in WAIT.
module sme_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [7:0] chardata0,
    input  logic [7:0] chardata1,
    input  logic       isstring0,
    input  logic       isstring1,
    input  logic       ispattern0,
    input  logic       ispattern1,
    output logic [1:0] done,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic [7:0] sme_chardata,
    output logic       sme_isstring,
    output logic       sme_ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       busy
);

    typedef enum logic [2:0] {StIdle, StStream, StWait, StReport, StGap} state_e;

    state_e     state;
    logic       last_gnt;  // 1: requester 1 was served last
    logic       seen_char;
    logic [7:0] sel_char;
    logic       sel_str;
    logic       sel_pat;
    logic       pick1;

`ifdef SME_ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        sel_char = chardata0;
        sel_str  = isstring0;
        sel_pat  = ispattern0;
        if (gnt[1]) begin
            sel_char = chardata1;
            sel_str  = isstring1;
            sel_pat  = ispattern1;
        end
    end

    // On contention the requester not served last wins.
    assign pick1 = req[1] & (~req[0] | ~last_gnt);
    assign busy  = (state != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            gnt           <= 2'b00;
            done          <= 2'b00;
            res_match     <= 1'b0;
            res_index     <= 5'd0;
            res_timeout   <= 1'b0;
            sme_chardata  <= 8'd0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            last_gnt      <= 1'b1;
            seen_char     <= 1'b0;
`ifdef SME_ARB_TIMEOUT_EN
            wait_cnt      <= 8'd0;
`endif
        end else begin
            done <= 2'b00;
            unique case (state)
                StIdle: begin
                    if (|req) begin
                        gnt       <= pick1 ? 2'b10 : 2'b01;
                        seen_char <= 1'b0;
                        state     <= StStream;
                    end
                end
                StStream: begin
                    if (seen_char && !sel_str && !sel_pat) begin
                        sme_chardata  <= 8'd0;
                        sme_isstring  <= 1'b0;
                        sme_ispattern <= 1'b0;
                        state         <= StWait;
`ifdef SME_ARB_TIMEOUT_EN
                        wait_cnt      <= 8'd0;
`endif
                    end else begin
                        sme_chardata  <= sel_char;
                        sme_isstring  <= sel_str;
                        sme_ispattern <= sel_pat;
                        if (sel_str || sel_pat) seen_char <= 1'b1;
                    end
                end
                StWait: begin
                    if (sme_valid) begin
                        res_match   <= sme_match;
                        res_index   <= sme_match_index;
                        res_timeout <= 1'b0;
                        done        <= gnt;
                        state       <= StReport;
`ifdef SME_ARB_TIMEOUT_EN
                    end else if (wait_cnt == TimeoutLast) begin
                        res_match   <= 1'b0;
                        res_index   <= 5'd0;
                        res_timeout <= 1'b1;
                        done        <= gnt;
                        state       <= StReport;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                StReport: begin
                    last_gnt <= gnt[1];
                    gnt      <= 2'b00;
                    state    <= StGap;
                end
                StGap: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_arbiter.sv
// Self-checking bench for sme_arbiter: per-cycle reference model plus directed literal checks.
module tb_sme_arbiter;

    localparam int TimeoutCycles = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] chardata0 = 8'd0;
    logic [7:0] chardata1 = 8'd0;
    logic       isstring0 = 1'b0;
    logic       isstring1 = 1'b0;
    logic       ispattern0 = 1'b0;
    logic       ispattern1 = 1'b0;
    logic       sme_valid = 1'b0;
    logic       sme_match = 1'b0;
    logic [4:0] sme_match_index = 5'd0;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_timeout;
    logic [7:0] sme_chardata;
    logic       sme_isstring;
    logic       sme_ispattern;
    logic       busy;

    int checks = 0;
    int errors = 0;

    sme_arbiter #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .gnt             (gnt),
        .chardata0       (chardata0),
        .chardata1       (chardata1),
        .isstring0       (isstring0),
        .isstring1       (isstring1),
        .ispattern0      (ispattern0),
        .ispattern1      (ispattern1),
        .done            (done),
        .res_match       (res_match),
        .res_index       (res_index),
        .res_timeout     (res_timeout),
        .sme_chardata    (sme_chardata),
        .sme_isstring    (sme_isstring),
        .sme_ispattern   (sme_ispattern),
        .sme_valid       (sme_valid),
        .sme_match       (sme_match),
        .sme_match_index (sme_match_index),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: job phase 0 idle, 1 streaming, 2 waiting, 3 reporting, 4 gap.
    int         m_phase;
    int         m_who;
    int         m_last;
    int         m_fwd;
    int         m_waited;
    logic [1:0] e_gnt;
    logic [1:0] e_done;
    logic       e_match;
    logic [4:0] e_idx;
    logic       e_to;
    logic [7:0] e_char;
    logic       e_str;
    logic       e_pat;
    logic [7:0] in_c;
    logic       in_s;
    logic       in_p;
    bit         timeout_en;

    initial begin
        timeout_en = 1'b0;
`ifdef SME_ARB_TIMEOUT_EN
        timeout_en = 1'b1;
`endif
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_who = 0; m_last = 1; m_fwd = 0; m_waited = 0;
            e_gnt = 2'b00; e_done = 2'b00; e_match = 1'b0; e_idx = 5'd0; e_to = 1'b0;
            e_char = 8'd0; e_str = 1'b0; e_pat = 1'b0;
        end else begin
            in_c = (m_who == 1) ? chardata1 : chardata0;
            in_s = (m_who == 1) ? isstring1 : isstring0;
            in_p = (m_who == 1) ? ispattern1 : ispattern0;
            e_done = 2'b00;
            e_char = 8'd0; e_str = 1'b0; e_pat = 1'b0;
            if (m_phase == 0) begin
                if (req != 2'b00) begin
                    if (req == 2'b11) m_who = 1 - m_last;
                    else m_who = req[1] ? 1 : 0;
                    e_gnt = (m_who == 1) ? 2'b10 : 2'b01;
                    m_fwd = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_fwd > 0 && !in_s && !in_p) begin
                    m_waited = 0;
                    m_phase = 2;
                end else begin
                    e_char = in_c; e_str = in_s; e_pat = in_p;
                    if (in_s || in_p) m_fwd++;
                end
            end else if (m_phase == 2) begin
                m_waited++;
                if (sme_valid) begin
                    e_match = sme_match; e_idx = sme_match_index; e_to = 1'b0;
                    e_done = e_gnt;
                    m_phase = 3;
                end else if (timeout_en && m_waited == TimeoutCycles) begin
                    e_match = 1'b0; e_idx = 5'd0; e_to = 1'b1;
                    e_done = e_gnt;
                    m_phase = 3;
                end
            end else if (m_phase == 3) begin
                m_last = m_who;
                e_gnt = 2'b00;
                m_phase = 4;
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("done", 32'(done), 32'(e_done));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("res_match", 32'(res_match), 32'(e_match));
            chk("res_index", 32'(res_index), 32'(e_idx));
            chk("res_timeout", 32'(res_timeout), 32'(e_to));
            chk("sme_chardata", 32'(sme_chardata), 32'(e_char));
            chk("sme_isstring", 32'(sme_isstring), 32'(e_str));
            chk("sme_ispattern", 32'(sme_ispattern), 32'(e_pat));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input int r, input logic [7:0] c, input logic s, input logic p);
        if (r == 0) begin
            chardata0 = c; isstring0 = s; ispattern0 = p;
        end else begin
            chardata1 = c; isstring1 = s; ispattern1 = p;
        end
    endtask

    // Starts in IDLE with req set so that r wins; ends back in IDLE.
    task automatic job(input int r, input logic m, input logic [4:0] ix, input bit drop);
        tick();
        chk("lit_gnt_start", 32'(gnt), (r == 1) ? 32'h2 : 32'h1);
        chk("lit_sme_idle_first", 32'(sme_isstring), 32'h0);
        put(r, 8'h61, 1'b1, 1'b0);
        put(1 - r, 8'h7a, 1'b1, 1'b1);
        tick();
        put(r, 8'h62, 1'b1, 1'b0);
        chk("lit_sme_char_a", 32'(sme_chardata), 32'h61);
        chk("lit_sme_str_a", 32'(sme_isstring), 32'h1);
        tick();
        put(r, 8'h62, 1'b0, 1'b1);
        tick();
        chk("lit_sme_pat_b", 32'(sme_ispattern), 32'h1);
        put(r, 8'h00, 1'b0, 1'b0);
        put(1 - r, 8'h00, 1'b0, 1'b0);
        tick();
        chk("lit_sme_off_wait", 32'(sme_chardata), 32'h0);
        if (drop) req[r] = 1'b0;
        tick();
        tick();
        chk("lit_busy_wait", 32'(busy), 32'h1);
        sme_valid = 1'b1; sme_match = m; sme_match_index = ix;
        tick();
        chk("lit_done", 32'(done), (r == 1) ? 32'h2 : 32'h1);
        chk("lit_res_match", 32'(res_match), 32'(m));
        chk("lit_res_index", 32'(res_index), 32'(ix));
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 5'd0;
        tick();
        chk("lit_gap_gnt", 32'(gnt), 32'h0);
        chk("lit_gap_done", 32'(done), 32'h0);
        tick();
    endtask

    initial begin
        tick();
        chk("lit_rst_gnt", 32'(gnt), 32'h0);
        chk("lit_rst_busy", 32'(busy), 32'h0);
        chk("lit_rst_done", 32'(done), 32'h0);
        chk("lit_rst_res", 32'({res_match, res_index, res_timeout}), 32'h0);
        chk("lit_rst_sme", 32'({sme_chardata, sme_isstring, sme_ispattern}), 32'h0);

        // Single job from requester 0.
        req = 2'b01;
        reset = 1'b0;
        job(0, 1'b1, 5'd1, 1'b0);
        req = 2'b00;
        tick();

        // Simultaneous requests: after the previous job requester 1 leads, then alternation.
        req = 2'b11;
        job(1, 1'b0, 5'd3, 1'b0);
        job(0, 1'b1, 5'd9, 1'b0);
        job(1, 1'b1, 5'd17, 1'b0);
        req = 2'b01;
        job(0, 1'b0, 5'd31, 1'b1);   // req dropped mid-job, done still expected
        req = 2'b10;
        job(1, 1'b1, 5'd7, 1'b0);
        req = 2'b00;
        tick();

        // Stray engine result while idle.
        sme_valid = 1'b1; sme_match = 1'b0; sme_match_index = 5'd20;
        tick();
        tick();
        chk("lit_stray_done", 32'(done), 32'h0);
        chk("lit_stray_match", 32'(res_match), 32'h1);
        chk("lit_stray_index", 32'(res_index), 32'd7);
        sme_valid = 1'b0; sme_match_index = 5'd0;
        tick();

        // Reset while waiting on the engine.
        req = 2'b01;
        tick();
        put(0, 8'h61, 1'b1, 1'b0);
        tick();
        put(0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        chk("lit_wait_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("lit_rstw_busy", 32'(busy), 32'h0);
        chk("lit_rstw_gnt", 32'(gnt), 32'h0);
        chk("lit_rstw_index", 32'(res_index), 32'h0);
        tick();
        chk("lit_rstw_done", 32'(done), 32'h0);
        req = 2'b00;
        reset = 1'b0;
        tick();
        chk("lit_after_rst_busy", 32'(busy), 32'h0);

`ifdef SME_ARB_TIMEOUT_EN
        begin
            int n;
            bit seen;
            req = 2'b01;
            tick();
            put(0, 8'h61, 1'b0, 1'b1);
            tick();
            put(0, 8'h00, 1'b0, 1'b0);
            tick();
            n = 0;
            seen = 1'b0;
            while (!seen && n < 300) begin
                tick();
                n++;
                if (done != 2'b00) seen = 1'b1;
            end
            chk("lit_to_seen", 32'(seen), 32'h1);
            chk("lit_to_latency", 32'(n), 32'd255);
            chk("lit_to_flag", 32'(res_timeout), 32'h1);
            chk("lit_to_match", 32'(res_match), 32'h0);
            req = 2'b00;
            tick();
            tick();
        end
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
